// File: rtl/aq_axis_fifo36_ctrl.sv
// Controller for one FIFO36E2 (common clock, FWFT, 72-bit): reset sequencing, soft flush and AXI4-Stream bridging.
// Optional beat/occupancy counters are enabled with `define AQ_FIFO36_CTRL_STATS_EN.
module aq_axis_fifo36_ctrl #(
    parameter int unsigned RST_CYCLES   = 5,
    parameter int unsigned BUSY_TIMEOUT = 1023,
    parameter bit          TLAST_EN     = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        flush,
    output logic        ready,
    output logic        timeout_err,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        fifo_rst,
    output logic        fifo_wren,
    output logic [63:0] fifo_din,
    output logic [7:0]  fifo_dinp,
    input  logic        fifo_full,
    output logic        fifo_rden,
    input  logic [63:0] fifo_dout,
    input  logic [7:0]  fifo_doutp,
    input  logic        fifo_empty,
    input  logic        fifo_wrrstbusy,
    input  logic        fifo_rdrstbusy,
    output logic [1:0]  state_dbg
`ifdef AQ_FIFO36_CTRL_STATS_EN
    ,
    output logic [31:0] wr_beats,
    output logic [31:0] rd_beats,
    output logic [13:0] level
`endif
);

    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        BUSY_WAIT = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_t;

    localparam logic [9:0] RST_LAST = 10'(RST_CYCLES - 1);
    localparam logic [9:0] BUSY_MAX = 10'(BUSY_TIMEOUT);

    state_t     state, state_nxt;
    logic [9:0] cnt, cnt_nxt;
    logic       qual, qual_nxt;
    logic       busy;
    logic       in_run;
    logic       unused_doutp;

    assign busy         = fifo_wrrstbusy | fifo_rdrstbusy;
    assign in_run       = (state == RUN);
    assign state_dbg    = state;
    assign unused_doutp = ^fifo_doutp[7:1];

    // Streams: valid/ready handshake completes on a cycle where both are high;
    // the FIFO strobes are exactly those handshakes, so FULL/EMPTY are never violated.
    assign s_axis_tready = in_run & ~fifo_full;
    assign fifo_wren     = s_axis_tvalid & s_axis_tready;
    assign fifo_din      = s_axis_tdata;
    assign fifo_dinp     = TLAST_EN ? {7'b0, s_axis_tlast} : 8'b0;
    assign m_axis_tvalid = in_run & ~fifo_empty;
    assign fifo_rden     = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = fifo_dout;
    assign m_axis_tlast  = TLAST_EN & fifo_doutp[0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        qual_nxt  = qual;
        case (state)
            RST_HOLD: begin
                if (cnt == RST_LAST) begin
                    state_nxt = BUSY_WAIT;
                    cnt_nxt   = '0;
                    qual_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            BUSY_WAIT: begin
                // qual remembers one quiet cycle; a busy glitch drops it but cnt keeps running
                cnt_nxt  = cnt + 10'd1;
                qual_nxt = ~busy;
                if (!busy && qual)
                    state_nxt = RUN;
                else if (cnt == BUSY_MAX)
                    state_nxt = FAULT;
            end
            RUN, FAULT: begin
                if (flush) begin
                    state_nxt = RST_HOLD;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = RST_HOLD;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= RST_HOLD;
            cnt         <= '0;
            qual        <= 1'b0;
            fifo_rst    <= 1'b1;
            ready       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            qual     <= qual_nxt;
            fifo_rst <= (state_nxt == RST_HOLD);
            ready    <= (state_nxt == RUN);
            if (state == BUSY_WAIT && state_nxt == FAULT)
                timeout_err <= 1'b1;
        end
    end

`ifdef AQ_FIFO36_CTRL_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn || state_nxt == RST_HOLD) begin
            wr_beats <= '0;
            rd_beats <= '0;
            level    <= '0;
        end else begin
            if (fifo_wren && wr_beats != 32'hFFFF_FFFF)
                wr_beats <= wr_beats + 32'd1;
            if (fifo_rden && rd_beats != 32'hFFFF_FFFF)
                rd_beats <= rd_beats + 32'd1;
            case ({fifo_wren, fifo_rden})
                2'b10:   level <= level + 14'd1;
                2'b01:   level <= level - 14'd1;
                default: level <= level;
            endcase
        end
    end
`endif

endmodule
